// File: rtl/dram_write_packer.sv
// rtl/dram_write_packer.sv - packs 16-bit pixels into 128-bit words behind a small output queue
module dram_write_packer #(
  parameter int unsigned FRAME_PIXELS = 921600,
  parameter int unsigned OUT_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         draw_write_valid,
  input  logic [15:0]  dram_write_data,
  input  logic         dram_write_last,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [127:0] word_data,
  output logic         word_last,
  output logic         frame_done,
  output logic         overflow,
  output logic         frame_error,
  input  logic         clear_flags
);

  localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [20:0] FRAME_LEN = 21'(FRAME_PIXELS);
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(OUT_DEPTH);

  logic [127:0] acc_q, acc_d, merged;
  logic [2:0]   idx_q, idx_d;
  logic [19:0]  cnt_q, cnt_d;
  logic [20:0]  cnt_inc;
  logic         done_q, done_d;
  logic         ovf_q, ovf_d;
  logic         ferr_q, ferr_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]  occ_q, occ_d;
  logic [128:0] mem_q [OUT_DEPTH];

  logic commit, pop, full, push, drop, len_bad;

  // The incoming pixel is merged combinationally so a committed word includes it.
  always_comb begin
    merged = acc_q;
    merged[{idx_q, 4'b0000} +: 16] = dram_write_data;
  end

  assign commit  = draw_write_valid && (idx_q == 3'd7 || dram_write_last);
  assign pop     = (occ_q != '0) && word_ready;
  assign full    = (occ_q == DEPTH_CNT);
  assign push    = commit && (!full || pop);
  assign drop    = commit && !push;
  assign cnt_inc = {1'b0, cnt_q} + 21'd1;
  assign len_bad = (cnt_q == '1) || (cnt_inc != FRAME_LEN);

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (draw_write_valid) begin
      if (commit) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = merged;
        idx_d = idx_q + 3'd1;
      end
      if (dram_write_last)  cnt_d = '0;
      else if (cnt_q != '1) cnt_d = cnt_q + 20'd1;
    end
  end

  always_comb begin
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  // A set event wins over clear_flags in the same cycle.
  always_comb begin
    done_d = draw_write_valid && dram_write_last;
    ovf_d  = drop ? 1'b1 : (clear_flags ? 1'b0 : ovf_q);
    ferr_d = (draw_write_valid && dram_write_last && len_bad) ? 1'b1
           : (clear_flags ? 1'b0 : ferr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {dram_write_last, merged};
  end

  assign word_valid  = (occ_q != '0);
  assign word_data   = word_valid ? mem_q[rd_q][127:0] : '0;
  assign word_last   = word_valid ? mem_q[rd_q][128]   : 1'b0;
  assign frame_done  = done_q;
  assign overflow    = ovf_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_dram_write_packer.sv
// tb/tb_dram_write_packer.sv - directed self-checking bench for dram_write_packer
module tb_dram_write_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         draw_write_valid = 1'b0;
  logic [15:0]  dram_write_data = '0;
  logic         dram_write_last = 1'b0;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic [127:0] word_data;
  logic         word_last;
  logic         frame_done;
  logic         overflow;
  logic         frame_error;
  logic         clear_flags = 1'b0;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  logic [128:0] cap_q [$];

  always #5 clk = ~clk;

  dram_write_packer #(.FRAME_PIXELS(16), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .draw_write_valid(draw_write_valid), .dram_write_data(dram_write_data),
    .dram_write_last(dram_write_last),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .word_last(word_last), .frame_done(frame_done), .overflow(overflow),
    .frame_error(frame_error), .clear_flags(clear_flags)
  );

  // Record handshakes and done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) cap_q.push_back({word_last, word_data});
    if (frame_done) done_pulses++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pix(input logic [15:0] d, input logic l);
    draw_write_valid = 1'b1;
    dram_write_data  = d;
    dram_write_last  = l;
    step();
    draw_write_valid = 1'b0;
    dram_write_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    cap_q.delete();
    done_pulses = 0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", 128'(word_valid), 128'd0);
    check("rst_data", word_data, 128'd0);
    check("rst_flags", 128'({word_last, frame_done, overflow, frame_error}), 128'd0);

    // Exact-length frame of 16 pixels
    word_ready = 1'b1;
    for (int i = 1; i <= 16; i++) pix(16'(i), i == 16);
    idle(4);
    check("t1_nwords", 128'(cap_q.size()), 128'd2);
    if (cap_q.size() == 2) begin
      check("t1_w0", cap_q[0][127:0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      check("t1_w0_last", 128'(cap_q[0][128]), 128'd0);
      check("t1_w1", cap_q[1][127:0], 128'h0010_000F_000E_000D_000C_000B_000A_0009);
      check("t1_w1_last", 128'(cap_q[1][128]), 128'd1);
    end
    check("t1_done", 128'(done_pulses), 128'd1);
    check("t1_ferr", 128'(frame_error), 128'd0);

    // Short frame of 11 pixels with a partial final word
    cap_q.delete();
    done_pulses = 0;
    for (int i = 0; i < 11; i++) pix(16'hA000 + 16'(i), i == 10);
    idle(4);
    check("t2_nwords", 128'(cap_q.size()), 128'd2);
    if (cap_q.size() == 2) begin
      check("t2_w0", cap_q[0][127:0], 128'hA007_A006_A005_A004_A003_A002_A001_A000);
      check("t2_w1", cap_q[1][127:0], 128'h0000_0000_0000_0000_0000_A00A_A009_A008);
      check("t2_w1_last", 128'(cap_q[1][128]), 128'd1);
    end
    check("t2_ferr", 128'(frame_error), 128'd1);
    check("t2_done", 128'(done_pulses), 128'd1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("t2_ferr_clr", 128'(frame_error), 128'd0);

    // Stalled consumer: 40 pixels, 5 commits, 1 dropped
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 40; i++) pix(16'h0100 + 16'(i), 1'b0);
    check("t3_ovf", 128'(overflow), 128'd1);
    check("t3_valid", 128'(word_valid), 128'd1);
    check("t3_head", word_data, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    idle(3);
    check("t3_head_stable", word_data, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    check("t3_last_stable", 128'(word_last), 128'd0);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("t6_ovf_clr", 128'(overflow), 128'd0);
    word_ready = 1'b1;
    idle(8);
    check("t3_nwords", 128'(cap_q.size()), 128'd4);
    if (cap_q.size() == 4) begin
      check("t3_w0", cap_q[0][127:0], 128'h0107_0106_0105_0104_0103_0102_0101_0100);
      check("t3_w1", cap_q[1][127:0], 128'h010F_010E_010D_010C_010B_010A_0109_0108);
      check("t3_w3", cap_q[3][127:0], 128'h011F_011E_011D_011C_011B_011A_0119_0118);
    end
    check("t3_empty", 128'(word_valid), 128'd0);

    // Full queue with a pop in the same cycle as the 5th commit
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 39; i++) pix(16'h0200 + 16'(i), 1'b0);
    word_ready = 1'b1;
    pix(16'h0227, 1'b0);
    word_ready = 1'b0;
    check("t4_ovf", 128'(overflow), 128'd0);
    check("t4_valid", 128'(word_valid), 128'd1);
    check("t4_head", word_data, 128'h020F_020E_020D_020C_020B_020A_0209_0208);
    word_ready = 1'b1;
    idle(8);
    check("t4_nwords", 128'(cap_q.size()), 128'd5);
    if (cap_q.size() == 5) begin
      check("t4_w0", cap_q[0][127:0], 128'h0207_0206_0205_0204_0203_0202_0201_0200);
      check("t4_w4", cap_q[4][127:0], 128'h0227_0226_0225_0224_0223_0222_0221_0220);
    end

    // Reset mid-frame with one word queued and a partial word pending
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 13; i++) pix(16'h0400 + 16'(i), 1'b0);
    check("t5_pre_valid", 128'(word_valid), 128'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 128'(word_valid), 128'd0);
    check("t5_rst_data", word_data, 128'd0);
    check("t5_rst_flags", 128'({word_last, frame_done, overflow, frame_error}), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap_q.delete();
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) pix(16'h0300 + 16'(i), 1'b0);
    idle(3);
    check("t5_nwords", 128'(cap_q.size()), 128'd1);
    if (cap_q.size() == 1) begin
      check("t5_w0", cap_q[0][127:0], 128'h0307_0306_0305_0304_0303_0302_0301_0300);
      check("t5_w0_last", 128'(cap_q[0][128]), 128'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
